// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph constants, segment bit positions and slot-state type for the seven-segment scan driver.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high glyphs, bit order g,f,e,d,c,b,a.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [15:0][6:0] GLYPH_ROM = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    typedef enum logic {
        SHOW,
        GAP
    } slot_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble-to-glyph decoder, active-high, dp in bit 7.
module seg7_hex_decode (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);
    import seg7_pkg::*;

    always_comb begin
        seg = SEG_OFF;
        seg[SEG_G:SEG_A] = GLYPH_ROM[nibble];
        seg[SEG_DP] = dp;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed common-anode seven-segment scanner.
// Optional leading-zero suppression is built when SEG7_LZ_SUPPRESS_EN is defined.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);
    import seg7_pkg::*;

    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [7:0] SEG_POL = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_POL = AN_ACTIVE_LOW != 0 ? '1 : '0;

    logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, pend_en, disp_en;
    logic [CW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;
    slot_state_t             state;
    logic                    slot_end, frame_end, lit_now;
    logic [3:0]              cur_nib;
    logic [7:0]              dec_seg, lit_seg;
    logic [NUM_DIGITS-1:0]   an_sel, lz_dark;

    assign slot_end  = slot_cnt == SLOT_LAST;
    assign frame_end = en && slot_end && idx == IDX_LAST;
    assign cur_nib   = disp_val[{idx, 2'b00} +: 4];
    assign an_sel    = NUM_DIGITS'(1) << idx;
    assign lit_now   = en && state == SHOW;

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .dp     (disp_dp[idx]),
        .seg    (dec_seg)
    );

`ifdef SEG7_LZ_SUPPRESS_EN
    logic lz_seen;

    // Walk down from the top digit; everything above the first nonzero nibble goes dark, digit 0 never does.
    always_comb begin
        lz_dark = '0;
        lz_seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            lz_seen = lz_seen | (disp_val[4*k +: 4] != 4'h0);
            lz_dark[k] = !lz_seen;
        end
    end
`else
    assign lz_dark = '0;
`endif

    assign lit_seg = !disp_en[idx] ? SEG_OFF : lz_dark[idx] ? {disp_dp[idx], 7'b0} : dec_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_en    <= '0;
            slot_cnt   <= '0;
            idx        <= '0;
            state      <= SHOW;
            frame_done <= 1'b0;
            seg_out    <= SEG_OFF ^ SEG_POL;
            an_out     <= AN_POL;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_en  <= digit_en;
            end
            // While disabled the display set tracks loads at once; otherwise it only swaps at the frame wrap.
            if (!en || frame_end) begin
                disp_val <= load ? value : pend_val;
                disp_dp  <= load ? dp_in : pend_dp;
                disp_en  <= load ? digit_en : pend_en;
            end
            if (!en) begin
                slot_cnt <= '0;
                idx      <= '0;
                state    <= SHOW;
            end else begin
                slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
                idx      <= !slot_end ? idx : idx == IDX_LAST ? '0 : idx + 1'b1;
                state    <= slot_end ? SHOW :
                            (state == SHOW && slot_cnt == SHOW_LAST && BLANK_CYCLES != 0) ? GAP : state;
            end
            frame_done <= frame_end;
            seg_out    <= (lit_now ? lit_seg : SEG_OFF) ^ SEG_POL;
            an_out     <= (lit_now ? an_sel : '0) ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, glyphs, tear-free loading, masking and en/rst recovery.
module tb_seg7_scan_driver;

`ifdef SEG7_LZ_SUPPRESS_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    localparam logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] value;
    logic [3:0]  dp_in, digit_en;
    logic [7:0]  seg_out, seg_nb;
    logic [3:0]  an_out, an_nb;
    logic        frame_done, fd_nb;
    logic [7:0]  first_seg;
    logic [3:0]  first_an;
    int          checks = 0;
    int          errors = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_nb (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .seg_out(seg_nb), .an_out(an_nb), .frame_done(fd_nb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic lz(input logic [15:0] v, input int k);
        return LZ_ON && k != 0 && (v >> (4*k)) == 16'h0;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] d, input logic [3:0] m, input int c);
        int k;
        logic [7:0] lit;
        k = c / 8;
        if (c % 8 >= 6) return 8'hFF;
        lit = !m[k] ? 8'h00 : lz(v, k) ? {d[k], 7'h00} : {d[k], GL[v[4*k +: 4]]};
        return ~lit;
    endfunction

    function automatic logic [3:0] exp_an(input int c);
        return (c % 8 >= 6) ? 4'hF : 4'hF ^ (4'h1 << (c / 8));
    endfunction

    // One full 32-cycle frame against the expected display set; optionally strobes load after cycle ld_at.
    task automatic run_frame(input string tag, input logic [15:0] v, input logic [3:0] d, input logic [3:0] m,
                             input int ld_at, input logic [15:0] lv, input logic [3:0] ld, input logic [3:0] lm);
        for (int c = 0; c < 32; c++) begin
            tick();
            if (c == 0) begin
                first_seg = seg_out;
                first_an  = an_out;
            end
            check($sformatf("%s c%0d seg", tag, c), seg_out, exp_seg(v, d, m, c));
            check($sformatf("%s c%0d an", tag, c), an_out, exp_an(c));
            check($sformatf("%s c%0d frame_done", tag, c), frame_done, c == 31);
            load = c == ld_at;
            if (c == ld_at) begin
                value    = lv;
                dp_in    = ld;
                digit_en = lm;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
        tick();
        tick();
        check("reset seg", seg_out, 8'hFF);
        check("reset an", an_out, 4'hF);
        check("reset frame_done", frame_done, 1'b0);
        rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h1234; dp_in = 4'h0; digit_en = 4'hF;
        run_frame("f0 dark", 16'h0000, 4'h0, 4'h0, -1, '0, '0, '0);
        run_frame("f1 1234", 16'h1234, 4'h0, 4'hF, -1, '0, '0, '0);
        check("glyph 4 seg", first_seg, 8'b10011001);
        check("glyph 4 an", first_an, 4'b1110);
        run_frame("f2 tear", 16'h1234, 4'h0, 4'hF, 17, 16'hABCD, 4'h0, 4'hF);
        run_frame("f3 abcd", 16'hABCD, 4'h0, 4'hF, 17, 16'h1234, 4'b0001, 4'b0101);
        check("glyph d seg", first_seg, 8'hA1);
        run_frame("f4 mask", 16'h1234, 4'b0001, 4'b0101, 17, 16'h0070, 4'h0, 4'hF);
        check("dp digit0 seg", first_seg, 8'h19);
        check("dp digit0 bit7", first_seg[7], 1'b0);
        run_frame("f5 0070", 16'h0070, 4'h0, 4'hF, 17, 16'h0000, 4'h0, 4'hF);
        run_frame("f6 0000", 16'h0000, 4'h0, 4'hF, -1, '0, '0, '0);
        for (int c = 0; c < 18; c++) tick();
        en = 1'b0;
        tick();
        check("en drop seg", seg_out, 8'hFF);
        check("en drop an", an_out, 4'hF);
        check("en drop nb an", an_nb, 4'hF);
        load = 1'b1; value = 16'h5555; dp_in = 4'h0; digit_en = 4'hF;
        tick();
        load = 1'b0;
        tick();
        tick();
        check("en low seg", seg_out, 8'hFF);
        check("en low an", an_out, 4'hF);
        check("en low frame_done", frame_done, 1'b0);
        en = 1'b1;
        tick();
        check("resume an", an_out, 4'b1110);
        check("resume seg", seg_out, 8'h92);
        check("resume nb an", an_nb, 4'b1110);
        check("resume nb seg", seg_nb, 8'h92);
        for (int c = 1; c < 6; c++) tick();
        for (int c = 6; c < 8; c++) begin
            tick();
            check($sformatf("resume gap c%0d an", c), an_out, 4'hF);
            check($sformatf("resume gap c%0d seg", c), seg_out, 8'hFF);
            check($sformatf("nb no gap c%0d an", c), an_nb, 4'b1110);
            check($sformatf("nb no gap c%0d seg", c), seg_nb, 8'h92);
        end
        tick();
        check("resume digit1 an", an_out, 4'b1101);
        check("resume digit1 seg", seg_out, 8'h92);
        check("nb digit1 an", an_nb, 4'b1101);
        for (int c = 9; c < 18; c++) tick();
        rst = 1'b1;
        tick();
        check("rst mid seg", seg_out, 8'hFF);
        check("rst mid an", an_out, 4'hF);
        check("rst mid nb an", an_nb, 4'hF);
        rst = 1'b0;
        tick();
        check("post rst an", an_out, 4'b1110);
        check("post rst seg", seg_out, 8'hFF);
        check("post rst frame_done", frame_done, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
